// File: rtl/ser_demux_pkg.sv
// ser_demux_pkg: shared FSM state encoding and frame constants for the serial demux router
package ser_demux_pkg;
  typedef enum logic [1:0] {IDLE, PORT, LEN, DATA} state_t;
  localparam logic START_BIT = 1'b0;
endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: loadable counter (up or saturating down) with a programmable terminal-count flag
module ser_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? load_val : inc ? count + 1'b1 : (dec && count != '0) ? count - 1'b1 : count;
  assign tc = count == term;
endmodule

// File: rtl/ser_demux_router.sv
// ser_demux_router: deframes a serial bit stream (start, port, length, data) and routes
// the data bits to one of NUM_PORTS registered outputs.
module ser_demux_router
  import ser_demux_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W = 4,
  localparam int PORT_W = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ser_in,
  input  logic                 ser_valid,
  input  logic                 abort,
  output logic [NUM_PORTS-1:0] p_data,
  output logic [NUM_PORTS-1:0] p_valid,
  output logic                 busy,
  output logic                 done,
  output logic [PORT_W-1:0]    cur_port
);
  localparam int CW = PORT_W > LEN_W ? PORT_W : LEN_W;
  state_t state, state_nxt;
  logic [PORT_W-1:0] port_sr, port_nxt;
  logic [LEN_W-1:0] len_sr, len_nxt, rem;
  logic [CW-1:0] bcnt;
  logic step, bit_tc, rem_tc;
  assign step = ser_valid && !abort;
  assign port_nxt = PORT_W'({port_sr, ser_in});
  assign len_nxt = LEN_W'({len_sr, ser_in});
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else if (ser_valid)
      unique case (state)
        IDLE: if (ser_in == START_BIT) state_nxt = PORT;
        PORT: if (bit_tc) state_nxt = LEN;
        LEN:  if (bit_tc) state_nxt = len_nxt == '0 ? IDLE : DATA;
        DATA: if (rem_tc) state_nxt = IDLE;
      endcase
  end
  // field bit counter: restarts from 0 whenever the FSM moves on
  ser_bit_counter #(.W(CW)) u_bit_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (abort || (step && state_nxt != state)),
    .inc     (step && (state == PORT || state == LEN)),
    .dec     (1'b0),
    .load_val('0),
    .term    (state == PORT ? CW'(PORT_W - 1) : CW'(LEN_W - 1)),
    .count   (bcnt),
    .tc      (bit_tc)
  );
  // remaining data bits: tc marks the final bit of the payload
  ser_bit_counter #(.W(LEN_W)) u_rem_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (abort || (step && state == LEN && bit_tc)),
    .inc     (1'b0),
    .dec     (step && state == DATA),
    .load_val(abort ? '0 : len_nxt),
    .term    (LEN_W'(1)),
    .count   (rem),
    .tc      (rem_tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      p_valid  <= '0;
      p_data   <= '0;
      port_sr  <= '0;
      len_sr   <= '0;
      cur_port <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= state_nxt != IDLE;
      done    <= step && ((state == LEN && bit_tc && len_nxt == '0) || (state == DATA && rem_tc));
      p_valid <= '0;
      p_data  <= '0;
      if (step && state == PORT) port_sr <= port_nxt;
      if (step && state == PORT && bit_tc) cur_port <= port_nxt;
      if (step && state == LEN) len_sr <= len_nxt;
      if (step && state == DATA) begin
        p_valid[cur_port] <= 1'b1;
        p_data[cur_port]  <= ser_in;
      end
    end
endmodule

// File: tb/tb_ser_demux_router.sv
// tb_ser_demux_router: table-driven, hand-sequenced and randomized checks of ser_demux_router
// against a frame-level model of the expected output events.
module tb_ser_demux_router;
  logic clk = 0, rst_n, ser_in, ser_valid, abort;
  logic [3:0] p_data, p_valid;
  logic busy, done;
  logic [1:0] cur_port;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [3:0] pv;
    logic [3:0] pd;
    logic       done;
    logic [1:0] port;
  } ev_t;

  typedef struct {
    logic [1:0]  port;
    int          len;
    logic [15:0] data;
    int          gap;
    int          exp_n;
    logic [15:0] exp_bits;
    logic [1:0]  exp_port;
    int          exp_done;
  } vec_t;

  ev_t obs[$], exp[$];

  ser_demux_router dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .abort(abort),
    .p_data(p_data), .p_valid(p_valid), .busy(busy), .done(done), .cur_port(cur_port)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n) begin
      checks++;
      if (p_valid != 0 && !$onehot(p_valid)) begin
        failures++;
        $display("FAIL onehot p_valid=%b at %0t", p_valid, $time);
      end
      if ((p_data & ~p_valid) != 0) begin
        failures++;
        $display("FAIL idle_data p_data=%b p_valid=%b at %0t", p_data, p_valid, $time);
      end
      if (p_valid != 0 || done) obs.push_back('{p_valid, p_data, done, cur_port});
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic b);
    @(negedge clk);
    ser_valid = v;
    ser_in = b;
  endtask

  task automatic flush();
    repeat (3) cyc(1'b0, 1'($urandom));
  endtask

  task automatic send_raw(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) cyc(1'b1, bits[k]);
  endtask

  task automatic send_frame(input logic [1:0] port, input int len, input logic [15:0] data,
                            input int gap, input bit rnd);
    bit q[$];
    logic [3:0] l;
    int g;
    l = 4'(len);
    q.push_back(1'b0);
    for (int i = 1; i >= 0; i--) q.push_back(port[i]);
    for (int i = 3; i >= 0; i--) q.push_back(l[i]);
    for (int i = len - 1; i >= 0; i--) q.push_back(data[i]);
    if (len == 0) exp.push_back('{4'b0, 4'b0, 1'b1, port});
    for (int i = len - 1; i >= 0; i--)
      exp.push_back('{4'b1 << port, {3'b0, data[i]} << port, i == 0, port});
    for (int k = 0; k < q.size(); k++) begin
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      if (k > 0) repeat (g) cyc(1'b0, 1'($urandom));
      cyc(1'b1, q[k]);
    end
  endtask

  task automatic compare_model(input string name);
    int n;
    chk({name, "_events"}, obs.size(), exp.size());
    n = obs.size() < exp.size() ? obs.size() : exp.size();
    for (int i = 0; i < n; i++) chk({name, "_ev"}, obs[i], exp[i]);
    obs.delete();
    exp.delete();
  endtask

  vec_t vecs[5];

  initial begin
    int n, dn;
    logic [15:0] bits;
    logic other;
    vecs[0] = '{2'd2, 3, 16'b101, 0, 3, 16'b101, 2'd2, 1};
    vecs[1] = '{2'd3, 0, 16'h0, 0, 0, 16'h0, 2'd3, 1};
    vecs[2] = '{2'd2, 3, 16'b101, 2, 3, 16'b101, 2'd2, 1};
    vecs[3] = '{2'd1, 2, 16'b10, 1, 2, 16'b10, 2'd1, 1};
    vecs[4] = '{2'd0, 15, 16'h4B2D, 0, 15, 16'h4B2D, 2'd0, 1};
    rst_n = 0; ser_valid = 0; ser_in = 0; abort = 0;
    #12 chk("reset_outs", {p_data, p_valid, busy, done, cur_port}, 0);
    @(posedge clk);
    #2 rst_n = 1;

    foreach (vecs[v]) begin
      send_frame(vecs[v].port, vecs[v].len, vecs[v].data, vecs[v].gap, 0);
      cyc(1'b0, 1'b0);
      chk("done_at_end", done, 1);
      chk("busy_end", busy, 0);
      flush();
      n = 0; dn = 0; bits = 0; other = 0;
      foreach (obs[i]) begin
        if (obs[i].pv != 0) begin
          n++;
          bits = {bits[14:0], obs[i].pd[vecs[v].exp_port]};
        end
        other |= |((obs[i].pv | obs[i].pd) & ~(4'b1 << vecs[v].exp_port));
        if (obs[i].done) dn++;
      end
      chk("tbl_strobes", n, vecs[v].exp_n);
      chk("tbl_bits", bits, vecs[v].exp_bits);
      chk("tbl_dones", dn, vecs[v].exp_done);
      chk("tbl_other_ports", other, 0);
      chk("tbl_cur_port", cur_port, vecs[v].exp_port);
      if (obs.size() > 0) chk("tbl_done_last", obs[obs.size()-1].done && (obs[obs.size()-1].pv != 0), vecs[v].exp_n > 0);
      compare_model("tbl");
    end

    // abort after the 2nd data bit of a LEN=5 frame to port 1
    send_raw(32'b0_01_0101_10, 9);
    @(negedge clk);
    chk("busy_mid", busy, 1);
    abort = 1; ser_valid = 1; ser_in = 1;
    @(negedge clk);
    abort = 0; ser_valid = 0;
    chk("abort_busy", busy, 0);
    chk("abort_pv", p_valid, 0);
    chk("abort_done", done, 0);
    repeat (3) cyc(1'b1, 1'b1);
    flush();
    exp.push_back('{4'b0010, 4'b0010, 1'b0, 2'd1});
    exp.push_back('{4'b0010, 4'b0000, 1'b0, 2'd1});
    compare_model("abort");
    chk("abort_port", cur_port, 1);

    // reset during DATA of a port-3 LEN=4 frame
    send_raw(32'b0_11_0100_11, 9);
    @(posedge clk);
    #1 chk("pre_rst_pv", {p_valid, p_data}, 8'b1000_1000);
    #1 rst_n = 0; ser_valid = 0;
    #1 chk("rst_async", {p_data, p_valid, busy, done, cur_port}, 0);
    @(posedge clk);
    #2 rst_n = 1;
    obs.delete();
    exp.delete();
    send_frame(2'd1, 2, 16'b01, 0, 0);
    cyc(1'b0, 1'b0);
    chk("rst_frame_done", done, 1);
    flush();
    compare_model("after_rst");

    // back-to-back frames
    send_frame(2'd0, 1, 16'b1, 0, 0);
    send_frame(2'd3, 2, 16'b10, 0, 0);
    cyc(1'b0, 1'b0);
    flush();
    dn = 0;
    foreach (obs[i]) dn += obs[i].done;
    chk("b2b_dones", dn, 2);
    compare_model("b2b");

    // randomized frames, gaps and idle-line ones
    repeat (40) begin
      repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b1);
      send_frame(2'($urandom), int'($urandom_range(0, 15)), 16'($urandom), 2, 1);
    end
    cyc(1'b0, 1'b0);
    flush();
    compare_model("random");
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ser_demux_router.md
SER_DEMUX_ROUTER -- requirements
Module: ser_demux_router

Interface
REQ-001 The module SHALL have parameter NUM_PORTS, default 4, the number of output ports (a power of 2, minimum 2).
REQ-002 The module SHALL have parameter LEN_W, default 4, the width of the frame length field in bits.
REQ-003 The module SHALL derive local parameter PORT_W = clog2(NUM_PORTS) as the port-field width.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 ser_in  input  1  serial data bit.
REQ-007 ser_valid  input  1  qualifies ser_in; a bit is consumed only on cycles where this is high.
REQ-008 abort  input  1  synchronous frame cancel.
REQ-009 p_data  output  NUM_PORTS  per-port routed data bit.
REQ-010 p_valid  output  NUM_PORTS  per-port one-cycle strobe for p_data.
REQ-011 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-012 done  output  1  one-cycle pulse on frame completion.
REQ-013 cur_port  output  PORT_W  latched destination port of the current or last frame.

Function
REQ-014 Frame format, all fields MSB-first, one bit per ser_valid cycle: start bit (0), then PORT_W port bits, then LEN_W length bits, then LEN data bits.
REQ-015 FSM states SHALL be IDLE, PORT, LEN, DATA.
REQ-016 IDLE: ser_valid with ser_in=0 -> PORT; ser_valid with ser_in=1 SHALL be ignored (line idle).
REQ-017 PORT: shift in PORT_W bits; after the last port bit -> LEN, and cur_port updates to the new value on that edge.
REQ-018 LEN: shift in LEN_W bits; after the last length bit, if LEN=0 -> IDLE with done asserted the next cycle, else -> DATA.
REQ-019 DATA: each valid bit SHALL appear on p_data[cur_port] with p_valid[cur_port]=1 exactly one cycle after sampling (registered, latency 1).
REQ-020 In DATA, after the LEN-th bit -> IDLE, and done SHALL assert in the same cycle as the final p_valid.
REQ-021 Non-selected ports SHALL hold p_data=0 and p_valid=0, and at most one p_valid bit SHALL be high in any cycle.
REQ-022 p_data of the selected port SHALL also return to 0 in cycles with no valid bit.
REQ-023 Cycles with ser_valid=0 SHALL leave the FSM, counters and shift registers unchanged (gaps allowed in any state).
REQ-024 The bit counter SHALL be max(PORT_W, LEN_W) bits wide and SHALL reload to 0 on each state change; the remaining-data counter is LEN_W bits and counts down to 0 without wrap.
REQ-025 abort=1 SHALL force IDLE on the next edge, suppress done and clear p_valid; abort takes priority over a simultaneous ser_valid; cur_port SHALL be retained.
REQ-026 After completion, a start bit arriving in the cycle immediately after the last data bit SHALL be accepted (back-to-back frames, no dead cycle).

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE and clear all counters and shift registers to 0.
REQ-028 rst_n low SHALL drive p_data=0, p_valid=0, busy=0, done=0 and cur_port=0.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no done pulse; release is synchronous to clk, with the first start bit accepted on the first edge after release.

Structure
REQ-030 A shared package ser_demux_pkg SHALL hold the FSM state enum (IDLE, PORT, LEN, DATA) and the START_BIT=0 constant.
REQ-031 The bit and length counting SHALL be a single sub-module, ser_bit_counter (load, decrement, terminal-count flag, parameterised width).
REQ-032 All outputs SHALL be registered; there SHALL be no combinational path from ser_in to p_data.

Verification (NUM_PORTS=4, LEN_W=4)
REQ-033 Basic frame: stream 0,1,0,0,0,1,1,1,0,1 (port 2, LEN 3, data 1,0,1) -> p_valid[2] pulses three times with p_data 1,0,1, done coincides with the third pulse, ports 0, 1 and 3 stay 0.
REQ-034 Zero length: start, port 3, LEN 0 -> no p_valid, done one cycle after the last length bit, cur_port=3, busy low thereafter.
REQ-035 Gaps: same stimulus as REQ-033 with ser_valid low for 2 cycles between every bit -> identical p_data sequence and done, with no extra or missing strobes.
REQ-036 Abort: abort=1 together with ser_valid after the 2nd data bit of a LEN=5 frame -> IDLE next cycle, no further p_valid, no done, busy=0.
REQ-037 Reset mid-DATA: rst_n low for 1 cycle during DATA -> all outputs 0 immediately (asynchronously), then a fresh frame to port 1 with LEN 2 routes correctly.
REQ-038 Back-to-back: a port-0 frame with LEN 1 followed immediately by a port-3 frame with LEN 2 -> one strobe on p_valid[0], then two strobes on p_valid[3], with two done pulses.
